spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_rr_pick.sv | 38 +++
 rtl/spi_arbiter.sv | 173 +++++++++++++++++
 tb/tb_spi_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI bus arbiter.
//   - spi_state_t : arbiter FSM state encoding
//   - SPI_N_REQ_DEF / SPI_TIMEOUT_DEF : default requester count and
//     idle-grant watchdog limit used by spi_arbiter
package spi_pkg;

    localparam int SPI_N_REQ_DEF   = 4;
    localparam int SPI_TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        LOAD,
        WAIT_START,
        XFER,
        DONE
    } spi_state_t;

endpackage

// File: rtl/spi_rr_pick.sv
// spi_rr_pick: combinational round-robin selector.
// Ports:
//   i_req  [N_REQ-1:0]       request vector
//   i_last [clog2(N_REQ)-1:0] index of the previous owner
//   o_pick [N_REQ-1:0]       one-hot winner (zero when no request)
//   o_idx  [clog2(N_REQ)-1:0] index of the winner
// Search starts at i_last+1 and wraps, so the previous owner has the
// lowest priority.
module spi_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_last,
    output logic [N_REQ-1:0]         o_pick,
    output logic [$clog2(N_REQ)-1:0] o_idx
);

    localparam int IW = $clog2(N_REQ);

    logic          w_found;
    logic [IW-1:0] w_j;

    always_comb begin
        o_pick  = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_j = IW'((int'(i_last) + k) % N_REQ);
            if (!w_found && i_req[w_j]) begin
                w_found     = 1'b1;
                o_pick[w_j] = 1'b1;
                o_idx       = w_j;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter sharing one SPI byte engine among
// N_REQ requesters.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req/gnt                    per-requester request level / one-hot grant
//   tx_data/tx_valid/tx_last   owner's byte offer (8 bits per requester)
//   tx_ready                   one-cycle byte-accept pulse to the owner
//   rx_data/rx_valid           received byte + one-cycle pulse to the owner
//   eng_data_in/eng_ready_send byte and start pulse to the engine
//   eng_busy/eng_data_out      engine status and received byte
//   timeout_err                one-cycle pulse on an idle-grant abort
// Optional feature: define SPI_ARB_TIMEOUT_EN to enable the GRANT-state
// watchdog (TIMEOUT cycles); otherwise GRANT is held indefinitely.
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int N_REQ   = SPI_N_REQ_DEF,
    parameter int TIMEOUT = SPI_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    output logic [N_REQ-1:0]   gnt,
    input  logic [8*N_REQ-1:0] tx_data,
    input  logic [N_REQ-1:0]   tx_valid,
    input  logic [N_REQ-1:0]   tx_last,
    output logic [N_REQ-1:0]   tx_ready,
    output logic [7:0]         rx_data,
    output logic [N_REQ-1:0]   rx_valid,
    output logic [7:0]         eng_data_in,
    output logic               eng_ready_send,
    input  logic               eng_busy,
    input  logic [7:0]         eng_data_out,
    output logic               timeout_err
);

    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
        $error("spi_arbiter: N_REQ or TIMEOUT out of range");
    end

    spi_state_t       r_state;
    logic [IW-1:0]    r_owner;      // current owner, doubles as last owner
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_tx_ready;
    logic [N_REQ-1:0] r_rx_valid;
    logic [7:0]       r_rx_data;
    logic [7:0]       r_eng_data_in;
    logic             r_eng_ready_send;
    logic             r_last;       // byte in flight closes the transaction

    logic [N_REQ-1:0] w_pick;
    logic [IW-1:0]    w_pick_idx;
    logic [7:0]       w_tx_bytes [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_tx_bytes[g] = tx_data[8*g +: 8];
    end

    spi_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req  (req),
        .i_last (r_owner),
        .o_pick (w_pick),
        .o_idx  (w_pick_idx)
    );

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0] r_tcnt;
    logic        r_timeout_err;

    // Counts cycles spent in GRANT; any other state clears it, so every
    // entry into GRANT (including burst re-entry from DONE) starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tcnt <= '0;
        else if (r_state == GRANT)
            r_tcnt <= r_tcnt + 16'd1;
        else
            r_tcnt <= '0;
    end

    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_owner          <= IW'(N_REQ - 1);
            r_gnt            <= '0;
            r_tx_ready       <= '0;
            r_rx_valid       <= '0;
            r_rx_data        <= '0;
            r_eng_data_in    <= '0;
            r_eng_ready_send <= 1'b0;
            r_last           <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            r_timeout_err    <= 1'b0;
`endif
        end else begin
            // pulse outputs default low
            r_tx_ready       <= '0;
            r_rx_valid       <= '0;
            r_eng_ready_send <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            r_timeout_err    <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_owner <= w_pick_idx;
                        r_gnt   <= w_pick;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (tx_valid[r_owner]) begin
                        r_state <= LOAD;
                    end else if (!req[r_owner]) begin
                        r_gnt   <= '0;
                        r_state <= IDLE;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (r_tcnt == 16'(TIMEOUT - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_gnt         <= '0;
                        r_state       <= IDLE;
                    end
`endif
                end
                LOAD: begin
                    r_eng_data_in       <= w_tx_bytes[r_owner];
                    r_tx_ready[r_owner] <= 1'b1;
                    r_eng_ready_send    <= 1'b1;
                    r_last              <= tx_last[r_owner];
                    r_state             <= WAIT_START;
                end
                WAIT_START: begin
                    if (eng_busy)
                        r_state <= XFER;
                end
                XFER: begin
                    if (!eng_busy)
                        r_state <= DONE;
                end
                DONE: begin
                    r_rx_data           <= eng_data_out;
                    r_rx_valid[r_owner] <= 1'b1;
                    if (r_last) begin
                        r_gnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_state <= GRANT;   // burst: keep the grant
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt            = r_gnt;
    assign tx_ready       = r_tx_ready;
    assign rx_valid       = r_rx_valid;
    assign rx_data        = r_rx_data;
    assign eng_data_in    = r_eng_data_in;
    assign eng_ready_send = r_eng_ready_send;

endmodule

// File: tb/tb_spi_arbiter.sv
module tb_spi_arbiter;

    localparam int N = 4;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TMO = 10;
`else
    localparam int TMO = 255;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   gnt;
    logic [8*N-1:0] tx_data = '0;
    logic [N-1:0]   tx_valid = '0;
    logic [N-1:0]   tx_last = '0;
    logic [N-1:0]   tx_ready;
    logic [7:0]     rx_data;
    logic [N-1:0]   rx_valid;
    logic [7:0]     eng_data_in;
    logic           eng_ready_send;
    logic           eng_busy = 1'b0;
    logic [7:0]     eng_data_out = '0;
    logic           timeout_err;

    spi_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .gnt            (gnt),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_last        (tx_last),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .eng_data_in    (eng_data_in),
        .eng_ready_send (eng_ready_send),
        .eng_busy       (eng_busy),
        .eng_data_out   (eng_data_out),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] gnt;
        logic [7:0]   tx;
        logic [7:0]   rx;
    } exp_t;

    typedef struct {
        int           rid;
        logic [7:0]   tx;
        logic [7:0]   rx;
        logic [N-1:0] gnt;
    } vec_t;

    exp_t         sb[$];
    logic [N-1:0] glog[$];
    logic [N-1:0] prev_gnt = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int starts = 0;

    // requester models
    logic [7:0] mem [N][8];
    logic       lst [N][8];
    int         ptr [N];
    int         cnt [N];
    logic       act [N];
    logic       hold [N];
    logic       junk = 1'b0;

    // engine model
    int         e_cnt = 0;
    logic [7:0] e_byte = '0;

    function automatic logic [7:0] resp(input logic [7:0] b);
        return b ^ 8'h99;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            logic b;
            b = act[i] && (ptr[i] < cnt[i]);
            req[i]         = b || hold[i];
            tx_valid[i]    = b || junk;
            tx_data[8*i +: 8] = b ? mem[i][ptr[i][2:0]] : 8'hEE;
            tx_last[i]     = b ? lst[i][ptr[i][2:0]] : junk;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0; hold[i] = 1'b0; ptr[i] = 0; cnt[i] = 0;
        end
        junk = 1'b0;
        drive();
    endtask

    task automatic add_byte(input int i, input logic [7:0] b, input logic l,
                            input logic [7:0] rx, input logic [N-1:0] g);
        exp_t e;
        mem[i][cnt[i][2:0]] = b;
        lst[i][cnt[i][2:0]] = l;
        cnt[i]++;
        e.gnt = g; e.tx = b; e.rx = rx;
        sb.push_back(e);
    endtask

    // One clock: sample #1 after the edge, run engine, scoreboard, requesters.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            eng_busy = 1'b0; e_cnt = 0;
        end else if (eng_ready_send) begin
            eng_busy = 1'b1; e_byte = eng_data_in; e_cnt = 3;
        end else if (e_cnt > 0) begin
            e_cnt--;
            if (e_cnt == 0) begin
                eng_busy = 1'b0; eng_data_out = resp(e_byte);
            end
        end
        if (gnt != prev_gnt && gnt != '0) glog.push_back(gnt);
        prev_gnt = gnt;
        total++;
        if ($countones(gnt) > 1) begin
            bad++;
            $display("FAIL gnt onehot: got=%b", gnt);
        end
        if (eng_ready_send) begin
            starts++;
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected start: data=%0h", eng_data_in);
            end else begin
                chk("eng_data_in", 32'(eng_data_in), 32'(sb[0].tx));
                chk("gnt at start", 32'(gnt), 32'(sb[0].gnt));
            end
        end
        if (rx_valid != '0) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected rx_valid: got=%b", rx_valid);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rx_data", 32'(rx_data), 32'(e.rx));
                chk("rx_valid", 32'(rx_valid), 32'(e.gnt));
            end
        end
        for (int i = 0; i < N; i++)
            if (tx_ready[i] && ptr[i] < cnt[i]) ptr[i]++;
        drive();
    endtask

    task automatic check_zero(input string nm);
        chk({nm, " outputs"},
            32'({gnt, tx_ready, rx_valid, eng_ready_send, timeout_err, rx_data, eng_data_in}), 0);
    endtask

    task automatic reset_now(input string nm);
        rst_n = 1'b0;
        clear_model();
        sb.delete();
        eng_busy = 1'b0; e_cnt = 0; eng_data_out = '0;
        #1;
        check_zero(nm);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        glog.delete();
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n;
        n = 0;
        while ((sb.size() != 0 || gnt != '0) && n < budget) begin
            tick();
            n++;
        end
        chk(nm, 32'(n < budget), 1);
    endtask

    task automatic wait_gnt(input logic [N-1:0] g, input int budget, input string nm);
        int n;
        n = 0;
        while (gnt !== g && n < budget) begin
            tick();
            n++;
        end
        chk(nm, 32'(gnt), 32'(g));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [5];
        int   n, k0, s0, seen;

        tbl[0] = '{0, 8'hA5, 8'h3C, 4'b0001};
        tbl[1] = '{3, 8'hFF, 8'h66, 4'b1000};
        tbl[2] = '{1, 8'h00, 8'h99, 4'b0010};
        tbl[3] = '{2, 8'h5A, 8'hC3, 4'b0100};
        tbl[4] = '{0, 8'h81, 8'h18, 4'b0001};

        #1;
        reset_now("reset");

        // single-byte transactions; idle requesters wave junk tx_valid/tx_last
        junk = 1'b1;
        for (int v = 0; v < 5; v++) begin
            s0 = starts;
            glog.delete();
            act[tbl[v].rid] = 1'b1;
            add_byte(tbl[v].rid, tbl[v].tx, 1'b1, tbl[v].rx, tbl[v].gnt);
            drive();
            wait_done(100, $sformatf("vec%0d complete", v));
            chk($sformatf("vec%0d grants", v), 32'(glog.size()), 1);
            chk($sformatf("vec%0d gnt", v), 32'(glog.size() > 0 ? glog[0] : 4'h0), 32'(tbl[v].gnt));
            chk($sformatf("vec%0d starts", v), 32'(starts - s0), 1);
            chk($sformatf("vec%0d gnt released", v), 32'(gnt), 0);
        end

        // round robin with all four requesting, two transactions each
        reset_now("reset rr");
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) begin
                logic [7:0] b;
                b = 8'h20 + 8'(16*r + i);
                add_byte(i, b, 1'b1, resp(b), 4'(1 << i));
            end
        for (int i = 0; i < N; i++) act[i] = 1'b1;
        drive();
        wait_done(400, "rr complete");
        chk("rr grants", 32'(glog.size()), 8);
        for (int k = 0; k < 8; k++) begin
            logic [N-1:0] w;
            w = 4'(1 << (k % 4));
            chk($sformatf("rr order %0d", k), 32'(k < glog.size() ? glog[k] : 4'h0), 32'(w));
        end

        // 3-byte burst from requester 2 while requester 0 waits
        reset_now("reset burst");
        add_byte(2, 8'h01, 1'b0, resp(8'h01), 4'b0100);
        add_byte(2, 8'h02, 1'b0, resp(8'h02), 4'b0100);
        add_byte(2, 8'h03, 1'b1, resp(8'h03), 4'b0100);
        add_byte(0, 8'h10, 1'b1, resp(8'h10), 4'b0001);
        act[2] = 1'b1;
        drive();
        wait_gnt(4'b0100, 10, "burst grant");
        act[0] = 1'b1;
        drive();
        wait_done(300, "burst complete");
        chk("burst grants", 32'(glog.size()), 2);
        chk("burst gnt0", 32'(glog.size() > 0 ? glog[0] : 4'h0), 32'(4'b0100));
        chk("burst gnt1", 32'(glog.size() > 1 ? glog[1] : 4'h0), 32'(4'b0001));

        // grant with no data: watchdog (if built) and req-drop release
        reset_now("reset hold");
        s0 = starts;
        hold[1] = 1'b1;
        drive();
        wait_gnt(4'b0010, 10, "hold grant");
        k0 = cyc;
`ifdef SPI_ARB_TIMEOUT_EN
        n = 0;
        while (!timeout_err && n < 40) begin
            tick();
            n++;
        end
        chk("timeout latency", 32'(cyc - k0), 32'(TMO));
        chk("timeout gnt", 32'(gnt), 0);
        hold[1] = 1'b0;
        drive();
        tick();
        chk("timeout pulse width", 32'(timeout_err), 0);
        hold[1] = 1'b1;
        drive();
        wait_gnt(4'b0010, 10, "regrant");
`else
        seen = 0;
        repeat (40) begin
            tick();
            if (timeout_err) seen++;
        end
        chk("no timeout pulses", 32'(seen), 0);
        chk("grant held", 32'(gnt), 32'(4'b0010));
`endif
        hold[1] = 1'b0;
        drive();
        n = 0;
        while (gnt !== '0 && n < 5) begin
            tick();
            n++;
        end
        chk("req drop release", 32'(gnt), 0);
        chk("no byte on idle grant", 32'(starts - s0), 0);

        // async reset during XFER, then a normal grant
        reset_now("reset pre-xfer");
        act[3] = 1'b1;
        add_byte(3, 8'h77, 1'b1, resp(8'h77), 4'b1000);
        drive();
        n = 0;
        while (!(eng_busy && !eng_ready_send && gnt == 4'b1000) && n < 20) begin
            tick();
            n++;
        end
        chk("reach xfer", 32'(n < 20), 1);
        reset_now("reset mid xfer");
        act[1] = 1'b1;
        add_byte(1, 8'h42, 1'b1, 8'hDB, 4'b0010);
        drive();
        wait_done(100, "post-reset complete");
        chk("post-reset grants", 32'(glog.size()), 1);
        chk("post-reset gnt", 32'(glog.size() > 0 ? glog[0] : 4'h0), 32'(4'b0010));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
